// File: rtl/timer_dev.sv
// timer_dev: programmable countdown timer on the bridge device port.
// Registers: 00 CTRL {IM, MODE[1:0], EN}, 01 PRESET, 10 COUNT (read-only), 11 reads 0.
// Optional macro TIMER_PRESCALE_EN: COUNT ticks once per PRESCALE clocks instead of every clock.
//
// state  | meaning
// S_IDLE | timer stopped, COUNT held
// S_LOAD | COUNT <= PRESET
// S_CNT  | counting down, zero detect leads to S_INT
// S_INT  | terminal count reached, irq raised when IM=1
module timer_dev #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdin,
    output logic [31:0] rd,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_CNT  = 2'b10,
        S_INT  = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic [31:0] w_count_nxt;
    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_en_eff;
    logic        w_auto_eff;
    logic        w_en_clr;
    logic        w_tick;
    logic        w_unused;

    // A CTRL write on this edge overrides the stored CTRL for FSM decisions.
    assign w_ctrl_wr   = we && (addr == 2'b00);
    assign w_preset_wr = we && (addr == 2'b01);
    assign w_en_eff    = w_ctrl_wr ? wdin[0] : r_en;
    assign w_auto_eff  = w_ctrl_wr ? (wdin[2:1] == 2'b01) : (r_mode == 2'b01);
    assign w_unused    = &{1'b0, wdin[31:4], PRESCALE != 0};

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] r_pre;

    assign w_tick = (r_pre == '0);

    // Prescale down-counter: reloads outside counting and on every tick.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_CNT) || w_tick) begin
            r_pre <= PW'(PRESCALE - 1);
        end else begin
            r_pre <= r_pre - 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next COUNT and one-shot EN clear.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_en_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_en_eff) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!w_en_eff) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    if (r_count == 32'd0) begin
                        w_state_nxt = S_INT;
                        w_en_clr    = !w_auto_eff && !w_ctrl_wr;
                    end else begin
                        w_count_nxt = r_count - 32'd1;
                    end
                end
            end
            S_INT: begin
                // Auto-reload: the INT cycle doubles as the reload cycle so the
                // irq period is PRESET+2 clocks.
                if (w_auto_eff) begin
                    if (!w_en_eff) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_preset;
                        w_state_nxt = S_CNT;
                    end
                end else if (w_ctrl_wr) begin
                    w_state_nxt = w_en_eff ? S_LOAD : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Register file and COUNT datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en     <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
        end else begin
            if (w_ctrl_wr) begin
                r_en   <= wdin[0];
                r_mode <= wdin[2:1];
                r_im   <= wdin[3];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end
            if (w_preset_wr) r_preset <= wdin;
            r_count <= w_count_nxt;
        end
    end

    // Combinational read mux.
    always_comb begin
        rd = 32'd0;
        case (addr)
            2'b00:   rd = {28'd0, r_im, r_mode, r_en};
            2'b01:   rd = r_preset;
            2'b10:   rd = r_count;
            default: rd = 32'd0;
        endcase
    end

    assign irq = (r_state == S_INT) && r_im;

endmodule
